// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IR, ready-handshake fetch, decoded fields.
// Define ALIGN_CHECK_EN to trap misaligned PCs instead of masking them.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        fetch_done,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic        fetch_misaligned,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [5:0]  OPCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  Funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        align_bad;

`ifdef ALIGN_CHECK_EN
  logic mis_q, mis_d;
  // Check the PC the upcoming REQ would actually use.
  assign align_bad = pc_write ? |pc_next[1:0] : |pc_q[1:0];
  assign fetch_misaligned = mis_q;
`else
  assign align_bad = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
`ifdef ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (pc_write) pc_d = pc_next;
        if (fetch_req) begin
          wait_d = 8'd0;
          if (align_bad) begin
            state_d = ERR;
`ifdef ALIGN_CHECK_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d = REQ;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == 8'(MAX_WAIT - 1)) state_d = ERR;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      wait_q  <= 8'd0;
`ifdef ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
`ifdef ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign mem_rd     = (state_q == REQ);
  assign fetch_busy = (state_q == REQ);
  assign fetch_done = (state_q == DONE);
  assign fetch_err  = (state_q == ERR);
  assign mem_addr   = mem_rd ? {pc_q[31:2], 2'b00} : pc_q;

  assign PC       = pc_q;
  assign PC_plus4 = pc_q + 32'd4;
  assign OPCode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign Funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign jaddr    = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with an expected-fetch queue.
// Build with +define+ALIGN_CHECK_EN to exercise the alignment trap.
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] pc_next = 32'd0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        fetch_done, fetch_busy, fetch_err, fetch_misaligned;
  logic [31:0] PC, PC_plus4;
  logic [5:0]  OPCode, Funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
    .Clock(Clock), .Reset(Reset),
    .fetch_req(fetch_req), .pc_write(pc_write), .pc_next(pc_next),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .fetch_done(fetch_done),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err),
    .fetch_misaligned(fetch_misaligned),
    .PC(PC), .PC_plus4(PC_plus4), .OPCode(OPCode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .Funct(Funct),
    .imm16(imm16), .jaddr(jaddr)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Drives one fetch and plays a memory with `waits` stall cycles.
  task automatic fetch(input logic [31:0] data, input int waits,
                       output int rd_cnt, output int busy_cnt,
                       output int done_cyc, output logic [31:0] addr);
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    rd_cnt = 0; busy_cnt = 0; done_cyc = -1; addr = 32'hDEAD_BEEF;
    for (int c = 0; c < 40; c++) begin
      if (fetch_done) begin done_cyc = c; break; end
      if (fetch_busy) busy_cnt++;
      if (mem_rd) begin
        rd_cnt++;
        addr = mem_addr;
        mem_rdata = data;
        mem_ready = (rd_cnt > waits);
      end
      tick;
      mem_ready = 1'b0;
    end
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    vectors++;
    if ({mem_rd, fetch_done, fetch_busy, fetch_err, fetch_misaligned} !== 5'b0 ||
        PC !== 32'h0 || jaddr !== 26'h0 || OPCode !== 6'h0) begin
      miscompares++;
      $display("FAIL reset: ctl=%b PC=%h ir=%h%h want ctl=0 PC=0 ir=0",
               {mem_rd, fetch_done, fetch_busy, fetch_err, fetch_misaligned},
               PC, OPCode, jaddr);
    end
    vectors++;
    if (PC_plus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_pc4: got %h want 00000004", PC_plus4);
    end
  endtask

  task automatic test_basic;
    int r, b, d; logic [31:0] a; exp_t e;
    exp_q.push_back('{ir: 32'h0000_2020, pc: 32'h4});
    fetch(32'h0000_2020, 0, r, b, d, a);
    vectors++;
    if (d !== 1) begin
      miscompares++;
      $display("FAIL basic_latency: done at +%0d want +1", d);
    end
    e = exp_q.pop_front();
    vectors++;
    if ({OPCode, rs, rt, rd, shamt, Funct} !== e.ir || PC !== e.pc ||
        Funct !== 6'h20 || OPCode !== 6'h0) begin
      miscompares++;
      $display("FAIL basic_fields: ir=%h PC=%h want ir=%h PC=%h",
               {OPCode, rs, rt, rd, shamt, Funct}, PC, e.ir, e.pc);
    end
    vectors++;
    if (a !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_addr: got %h want 0", a);
    end
    tick;
    vectors++;
    if (fetch_done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: done=%b want 0", fetch_done);
    end
  endtask

  task automatic test_wait;
    int r, b, d; logic [31:0] a; exp_t e;
    exp_q.push_back('{ir: 32'h2008_0005, pc: 32'h8});
    fetch(32'h2008_0005, 3, r, b, d, a);
    vectors++;
    if (r !== 4 || b !== 4 || d !== 4) begin
      miscompares++;
      $display("FAIL wait_cycles: rd=%0d busy=%0d done=+%0d want 4 4 +4",
               r, b, d);
    end
    e = exp_q.pop_front();
    vectors++;
    if (OPCode !== 6'h08 || rt !== 5'd8 || imm16 !== 16'd5 ||
        PC !== e.pc || {OPCode, jaddr} !== e.ir) begin
      miscompares++;
      $display("FAIL wait_fields: op=%h rt=%0d imm=%h PC=%h want 08 8 0005 %h",
               OPCode, rt, imm16, PC, e.pc);
    end
  endtask

  task automatic test_pc_write;
    int r, b, d; logic [31:0] a;
    pc_write = 1'b1; pc_next = 32'h40;
    tick;
    pc_write = 1'b0;
    vectors++;
    if (PC !== 32'h40) begin
      miscompares++;
      $display("FAIL pcw_idle: PC=%h want 00000040", PC);
    end
    exp_q.push_back('{ir: 32'h1234_5678, pc: 32'h44});
    fetch(32'h1234_5678, 1, r, b, d, a);
    vectors++;
    if (a !== 32'h40 || d !== 2) begin
      miscompares++;
      $display("FAIL pcw_addr: addr=%h done=+%0d want 00000040 +2", a, d);
    end
    vectors++;
    if (PC !== exp_q[0].pc || jaddr !== exp_q[0].ir[25:0]) begin
      miscompares++;
      $display("FAIL pcw_done: PC=%h want %h", PC, exp_q[0].pc);
    end
    void'(exp_q.pop_front());
    tick;
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    pc_write = 1'b1; pc_next = 32'h100;
    mem_rdata = 32'h0; mem_ready = 1'b1;
    tick;
    pc_write = 1'b0; mem_ready = 1'b0;
    vectors++;
    if (PC !== 32'h48 || fetch_done !== 1'b1) begin
      miscompares++;
      $display("FAIL pcw_req: PC=%h done=%b want 00000048 1", PC, fetch_done);
    end
    pc_write = 1'b1; pc_next = 32'h200;
    tick;
    pc_write = 1'b0;
    vectors++;
    if (PC !== 32'h200) begin
      miscompares++;
      $display("FAIL pcw_done_override: PC=%h want 00000200", PC);
    end
  endtask

  task automatic test_timeout;
    int r; int errc;
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    r = 0; errc = -1;
    for (int c = 0; c < 40; c++) begin
      if (fetch_err) begin errc = c; break; end
      if (mem_rd) r++;
      tick;
    end
    vectors++;
    if (r !== 15 || errc !== 15 || mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: rd=%0d err_at=%0d mem_rd=%b want 15 15 0",
               r, errc, mem_rd);
    end
    fetch_req = 1'b1; mem_ready = 1'b1;
    r = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (mem_rd || !fetch_err || fetch_done) r++;
    end
    fetch_req = 1'b0; mem_ready = 1'b0;
    vectors++;
    if (r !== 0) begin
      miscompares++;
      $display("FAIL err_sticky: %0d bad cycles want 0", r);
    end
    do_reset;
    vectors++;
    if (fetch_err !== 1'b0 || PC !== 32'h0) begin
      miscompares++;
      $display("FAIL err_reset: err=%b PC=%h want 0 0", fetch_err, PC);
    end
  endtask

  task automatic test_wrap_and_abort;
    int r, b, d; logic [31:0] a;
    pc_write = 1'b1; pc_next = 32'hFFFF_FFFC;
    tick;
    pc_write = 1'b0;
    exp_q.push_back('{ir: 32'h0800_0010, pc: 32'h0});
    fetch(32'h0800_0010, 0, r, b, d, a);
    vectors++;
    if (PC !== exp_q[0].pc || a !== 32'hFFFF_FFFC || jaddr !== 26'h10) begin
      miscompares++;
      $display("FAIL wrap: PC=%h addr=%h want 00000000 fffffffc", PC, a);
    end
    void'(exp_q.pop_front());
    tick;
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    Reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    vectors++;
    if (mem_rd !== 1'b0 || fetch_busy !== 1'b0 || PC !== 32'h0 ||
        jaddr !== 26'h0) begin
      miscompares++;
      $display("FAIL abort: rd=%b busy=%b PC=%h jaddr=%h want 0 0 0 0",
               mem_rd, fetch_busy, PC, jaddr);
    end
    Reset = 1'b1;
    tick;
    mem_ready = 1'b0;
    vectors++;
    if (fetch_done !== 1'b0 || mem_rd !== 1'b0 || OPCode !== 6'h0) begin
      miscompares++;
      $display("FAIL late_ready: done=%b rd=%b op=%h want 0 0 0",
               fetch_done, mem_rd, OPCode);
    end
  endtask

  task automatic test_align;
    int r, b, d; logic [31:0] a;
    pc_write = 1'b1; pc_next = 32'h2;
    fetch_req = 1'b1;
    tick;
    pc_write = 1'b0;
    fetch_req = 1'b0;
    r = 0; d = -1; a = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      if (mem_rd) begin
        r++; a = mem_addr; mem_ready = 1'b1; mem_rdata = 32'h0;
      end
      if (fetch_done && d < 0) d = c;
      tick;
      mem_ready = 1'b0;
    end
`ifdef ALIGN_CHECK_EN
    vectors++;
    if (fetch_err !== 1'b1 || fetch_misaligned !== 1'b1 || r !== 0) begin
      miscompares++;
      $display("FAIL align_trap: err=%b mis=%b rd=%0d want 1 1 0",
               fetch_err, fetch_misaligned, r);
    end
`else
    vectors++;
    if (a !== 32'h0 || r !== 1 || d !== 1 || PC !== 32'h6 ||
        fetch_err !== 1'b0 || fetch_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL align_mask: addr=%h rd=%0d done=+%0d PC=%h want 0 1 +1 6",
               a, r, d, PC);
    end
`endif
    do_reset;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait;
    test_pc_write;
    test_timeout;
    test_wrap_and_abort;
    test_align;
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
